eth_tx_frame_arbiter: RTL and testbench

Frame-level round-robin arbiter that shares the single TX MAC AXI-Stream slave port of the 10G Ethernet top among NUM_PORTS independent frame sources. It grants one source at a time and holds the grant from a frame's first beat to its tlast handshake, so frames are never interleaved. It also keeps per-port frame counters for debug and statistics. It sits directly upstream of the eth_10g_top `s_axis_*` interface in the TX clock domain.

---
 rtl/eth_tx_frame_arbiter_if.sv | 29 ++
 rtl/eth_tx_frame_arbiter.sv | 131 +++++++++++++
 tb/tb_eth_tx_frame_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_frame_arbiter_if.sv
// AXI-Stream bundle between NUM_PORTS frame sources and the single TX MAC port.
// The arbiter attaches through the slave modport. The source/MAC side
// (a bench or the surrounding top) attaches through the master modport.
interface eth_tx_frame_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_PORTS  = 4
);
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_axis_tkeep;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [NUM_PORTS-1:0]            s_axis_trdy;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic [KEEP_WIDTH-1:0]           m_axis_tkeep;
  logic                            m_axis_tvalid;
  logic                            m_axis_tlast;
  logic                            m_axis_trdy;

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_trdy,
    input  s_axis_trdy, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_trdy,
    output s_axis_trdy, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-level round-robin arbiter in front of the 10G TX MAC stream port.
// Holds a grant from first beat to the tlast handshake, so frames never
// interleave, and keeps a wrapping completed-frame counter per source.
module eth_tx_frame_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_PORTS  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  eth_tx_frame_arbiter_if.slave          axis,
  output logic [NUM_PORTS-1:0]           o_grant,
  output logic                           o_busy,
  output logic [NUM_PORTS*CNT_WIDTH-1:0] o_frame_cnt
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_PORTS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_PORTS];

  logic [IDX_W-1:0]     cand_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic                 win_found_s;
  logic                 last_hs_s;

  // Round-robin search: first requesting port at or after rr_ptr, wrapping.
  always_comb begin
    cand_s      = {IDX_W{1'b0}};
    win_idx_s   = {IDX_W{1'b0}};
    win_found_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_s = IDX_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
      if (!win_found_s && axis.s_axis_tvalid[cand_s]) begin
        win_idx_s   = cand_s;
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state logic plus the combinational datapath mux of the granted port.
  always_comb begin
    state_d            = state_q;
    rr_ptr_d           = rr_ptr_q;
    grant_idx_d        = grant_idx_q;
    cnt_d              = cnt_q;
    last_hs_s          = 1'b0;
    o_grant            = {NUM_PORTS{1'b0}};
    o_busy             = 1'b0;
    axis.s_axis_trdy   = {NUM_PORTS{1'b0}};
    axis.m_axis_tdata  = {DATA_WIDTH{1'b0}};
    axis.m_axis_tkeep  = {KEEP_WIDTH{1'b0}};
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tlast  = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          grant_idx_d = win_idx_s;
          state_d     = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        o_busy                        = 1'b1;
        o_grant[grant_idx_q]          = 1'b1;
        axis.m_axis_tdata             = axis.s_axis_tdata[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];
        axis.m_axis_tkeep             = axis.s_axis_tkeep[grant_idx_q*KEEP_WIDTH +: KEEP_WIDTH];
        axis.m_axis_tvalid            = axis.s_axis_tvalid[grant_idx_q];
        axis.m_axis_tlast             = axis.s_axis_tlast[grant_idx_q];
        axis.s_axis_trdy[grant_idx_q] = axis.m_axis_trdy;
        last_hs_s = axis.s_axis_tvalid[grant_idx_q] & axis.s_axis_tlast[grant_idx_q]
                    & axis.m_axis_trdy;
        if (last_hs_s) begin
          state_d = IDLE;
          if (grant_idx_q == IDX_W'(NUM_PORTS - 1)) begin
            rr_ptr_d = {IDX_W{1'b0}};
          end else begin
            rr_ptr_d = grant_idx_q + IDX_W'(1);
          end
          cnt_d[grant_idx_q] = cnt_q[grant_idx_q] + CNT_WIDTH'(1);
        end else begin
          state_d = XFER;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Flatten the per-port counters onto the status bus.
  always_comb begin
    o_frame_cnt = {(NUM_PORTS*CNT_WIDTH){1'b0}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      o_frame_cnt[p*CNT_WIDTH +: CNT_WIDTH] = cnt_q[p];
    end
  end

  // State, pointer and counter registers; reset drops any frame in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= {IDX_W{1'b0}};
      grant_idx_q <= {IDX_W{1'b0}};
      for (int p = 0; p < NUM_PORTS; p++) begin
        cnt_q[p] <= {CNT_WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Scoreboard bench for eth_tx_frame_arbiter: per-port source queues feed the
// DUT, expected MAC beats are queued in hand-derived grant order and a
// monitor compares every beat the MAC accepts.
module tb_eth_tx_frame_arbiter;

  localparam int DW = 32;
  localparam int KW = 4;
  localparam int NP = 4;
  localparam int CW = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [7:0]    gap;
  } src_beat_t;

  typedef struct packed {
    logic [7:0]    port;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } exp_beat_t;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     grant;
  logic              busy;
  logic [NP*CW-1:0]  frame_cnt;

  src_beat_t src_q [NP][$];
  exp_beat_t sb_q [$];
  logic [CW-1:0] exp_cnt [NP];
  logic          bp_mode;
  logic          after_last;
  int            errors;
  int            checks;

  eth_tx_frame_arbiter_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_PORTS(NP)) intf ();

  eth_tx_frame_arbiter #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .NUM_PORTS(NP), .CNT_WIDTH(CW)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .axis       (intf.slave),
    .o_grant    (grant),
    .o_busy     (busy),
    .o_frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] onehot(input int p);
    logic [NP-1:0] v;
    v = {{(NP-1){1'b0}}, 1'b1};
    return v << p;
  endfunction

  // Load a frame into a source queue and its expected beats into the scoreboard.
  task automatic push_frame(input int p, input int nb, input int fid,
                            input int stall_beat, input int stall_len);
    src_beat_t s;
    exp_beat_t e;
    for (int b = 0; b < nb; b++) begin
      s.data = {8'(p), 8'(fid), 16'(b)};
      s.keep = (b == nb - 1) ? 4'b0111 : 4'b1111;
      s.last = (b == nb - 1);
      s.gap  = (b == stall_beat) ? 8'(stall_len) : 8'd0;
      src_q[p].push_back(s);
      e.port = 8'(p);
      e.data = s.data;
      e.keep = s.keep;
      e.last = s.last;
      sb_q.push_back(e);
    end
    exp_cnt[p] = exp_cnt[p] + 4'd1;
  endtask

  task automatic check_counters(input string name);
    for (int p = 0; p < NP; p++) begin
      check(name, 32'(frame_cnt[p*CW +: CW]), 32'(exp_cnt[p]));
    end
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    int n;
    logic pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < max_cycles) begin
      @(negedge clk);
      n++;
      pending = busy || (sb_q.size() != 0);
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() != 0) pending = 1'b1;
      end
    end
    if (pending) begin
      errors++;
      $display("FAIL %s: timeout after %0d cycles, %0d beats outstanding", name, n, sb_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_grant(input string name, input logic [NP-1:0] g, input int max_cycles);
    int n;
    n = 0;
    while (grant !== g && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(grant), 32'(g));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_cnt[p] = 4'd0;
    end
    sb_q.delete();
    after_last = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Source driver: retire handshaken beats, then present each queue's head.
  initial begin
    logic [NP-1:0] hs;
    src_beat_t b;
    intf.s_axis_tdata  = '0;
    intf.s_axis_tkeep  = '0;
    intf.s_axis_tvalid = '0;
    intf.s_axis_tlast  = '0;
    intf.m_axis_trdy   = 1'b1;
    forever begin
      @(negedge clk);
      hs = intf.s_axis_tvalid & intf.s_axis_trdy;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (hs[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
        if (src_q[p].size() == 0) begin
          intf.s_axis_tvalid[p] = 1'b0;
          intf.s_axis_tlast[p]  = 1'b0;
          intf.s_axis_tdata[p*DW +: DW] = '0;
          intf.s_axis_tkeep[p*KW +: KW] = '0;
        end else begin
          b = src_q[p][0];
          if (b.gap != 8'd0) begin
            b.gap = b.gap - 8'd1;
            src_q[p][0] = b;
            intf.s_axis_tvalid[p] = 1'b0;
          end else begin
            intf.s_axis_tvalid[p] = 1'b1;
            intf.s_axis_tlast[p]  = b.last;
            intf.s_axis_tdata[p*DW +: DW] = b.data;
            intf.s_axis_tkeep[p*KW +: KW] = b.keep;
          end
        end
      end
      intf.m_axis_trdy = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare every presented beat against the scoreboard head.
  initial begin
    exp_beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (after_last) begin
          after_last = 1'b0;
          check("bubble_busy", 32'(busy), 32'd0);
          check("bubble_grant", 32'(grant), 32'd0);
          check("bubble_tvalid", 32'(intf.m_axis_tvalid), 32'd0);
          check("bubble_tdata", intf.m_axis_tdata, 32'd0);
        end
        if (intf.m_axis_tvalid) begin
          if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_beat: got data %0h expected none", intf.m_axis_tdata);
          end else begin
            e = sb_q[0];
            check("grant", 32'(grant), 32'(onehot(int'(e.port))));
            check("s_trdy", 32'(intf.s_axis_trdy),
                  32'(intf.m_axis_trdy ? onehot(int'(e.port)) : 4'b0000));
            if (intf.m_axis_trdy) begin
              void'(sb_q.pop_front());
              check("beat_data", intf.m_axis_tdata, e.data);
              check("beat_keep", 32'(intf.m_axis_tkeep), 32'(e.keep));
              check("beat_last", 32'(intf.m_axis_tlast), 32'(e.last));
              if (e.last) after_last = 1'b1;
            end
          end
        end
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    int n;
    errors = 0;
    checks = 0;
    bp_mode = 1'b0;
    after_last = 1'b0;
    for (int p = 0; p < NP; p++) exp_cnt[p] = 4'd0;
    rst = 1'b1;
    #1;
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_tvalid", 32'(intf.m_axis_tvalid), 32'd0);
    check("reset_cnt", 32'(frame_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single requester: 16-beat frame on port 2, one cycle arbitration latency.
    push_frame(2, 16, 1, -1, 0);
    n = 0;
    while (!intf.s_axis_tvalid[2] && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency_idle_grant", 32'(grant), 32'd0);
    @(negedge clk);
    check("latency_grant", 32'(grant), 32'(4'b0100));
    wait_drain("single_drain", 200);
    check("single_cnt2", 32'(frame_cnt[2*CW +: CW]), 32'd1);

    // Mid-frame reset: outputs and counters clear without a clock edge.
    push_frame(1, 8, 2, -1, 0);
    wait_grant("midreset_grant", 4'b0010, 20);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midreset_grant0", 32'(grant), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_tvalid", 32'(intf.m_axis_tvalid), 32'd0);
    check("midreset_trdy", 32'(intf.s_axis_trdy), 32'd0);
    check("midreset_cnt", 32'(frame_cnt), 32'd0);
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_cnt[p] = 4'd0;
    end
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fairness: all ports request two 3-beat frames; order 0,1,2,3,0,1,2,3.
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < NP; p++) push_frame(p, 3, 16 + f, -1, 0);
    end
    wait_drain("fair_drain", 400);
    for (int p = 0; p < NP; p++) check("fair_cnt", 32'(frame_cnt[p*CW +: CW]), 32'd2);

    // Backpressure on a port 1 frame.
    bp_mode = 1'b1;
    push_frame(1, 10, 3, -1, 0);
    wait_drain("bp_drain", 400);
    bp_mode = 1'b0;
    @(negedge clk);
    check_counters("bp_cnt");

    // No interleave: port 0 stalls 10 cycles mid-frame while port 3 waits.
    push_frame(0, 6, 4, 3, 10);
    wait_grant("ni_grant0", 4'b0001, 20);
    push_frame(3, 2, 5, -1, 0);
    n = 0;
    while (!(busy && !intf.s_axis_tvalid[0]) && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("ni_stall_grant", 32'(grant), 32'(4'b0001));
    check("ni_stall_trdy3", 32'(intf.s_axis_trdy[3]), 32'd0);
    check("ni_stall_tvalid", 32'(intf.m_axis_tvalid), 32'd0);
    wait_drain("ni_drain", 400);
    check_counters("ni_cnt");

    // Counter wrap: 17 single-beat frames on port 0 with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) push_frame(0, 1, 32 + i, -1, 0);
    wait_drain("wrap_drain", 400);
    check("wrap_cnt0", 32'(frame_cnt[CW-1:0]), 32'd1);
    check_counters("wrap_cnt");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
